// File: rtl/cram_arb_pkg.sv
// Shared widths, FSM encoding and command record for the cellular-RAM port arbiter.
package cram_arb_pkg;

  localparam int MST_W        = 3;
  localparam int BL_W         = 6;
  localparam int ADDR_W       = 30;
  localparam int INSTR_W      = 3;
  localparam int INSTR_RD_BIT = 0;
  localparam int DATA_W       = 32;
  localparam int MASK_W       = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [BL_W-1:0]    bl;
    logic [ADDR_W-1:0]  addr;
  } cmd_t;

endpackage

// File: rtl/cram_arb_if.sv
// Controller-side command/write/read port of the arbiter (MIG-style signal names).
interface cram_arb_if;
  import cram_arb_pkg::*;

  logic                mem_cmd_req;
  logic [INSTR_W-1:0]  mem_cmd_instr;
  logic [BL_W-1:0]     mem_cmd_bl;
  logic [ADDR_W-1:0]   mem_cmd_byte_addr;
  logic [MST_W-1:0]    mem_cmd_master;
  logic                mem_cmd_ack;
  logic [MASK_W-1:0]   mem_wr_mask;
  logic [DATA_W-1:0]   mem_wr_data;
  logic                mem_wr_ack;
  logic [MST_W-1:0]    mem_wr_master;
  logic                mem_rd_req;
  logic [DATA_W-1:0]   mem_rd_data;
  logic [MST_W-1:0]    mem_rd_master;

  modport master (
    output mem_cmd_req, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_cmd_master,
    output mem_wr_mask, mem_wr_data,
    input  mem_cmd_ack, mem_wr_ack, mem_wr_master, mem_rd_req, mem_rd_data, mem_rd_master
  );

  modport slave (
    input  mem_cmd_req, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_cmd_master,
    input  mem_wr_mask, mem_wr_data,
    output mem_cmd_ack, mem_wr_ack, mem_wr_master, mem_rd_req, mem_rd_data, mem_rd_master
  );

endinterface

// File: rtl/cram_arb_rr.sv
// Round-robin picker: first requester at or after ptr, wrapping at NUM_MST.
module cram_arb_rr
  import cram_arb_pkg::*;
#(
  parameter int NUM_MST = 4
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [MST_W-1:0]   ptr,
  output logic [NUM_MST-1:0] grant,
  output logic [MST_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_MST; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_MST) j = j - NUM_MST;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = MST_W'(j);
      end
    end
  end

endmodule

// File: rtl/cram_arb.sv
// N-master round-robin arbiter in front of the cellular-RAM controller port.
// Optional watchdog enabled by defining CRAM_ARB_TIMEOUT_EN.
module cram_arb
  import cram_arb_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                        mem_clk,
  input  logic                        mem_rst_n,
  input  logic                        init_done,
  input  logic [NUM_MST-1:0]          m_cmd_req,
  input  logic [INSTR_W*NUM_MST-1:0]  m_cmd_instr,
  input  logic [BL_W*NUM_MST-1:0]     m_cmd_bl,
  input  logic [ADDR_W*NUM_MST-1:0]   m_cmd_addr,
  output logic [NUM_MST-1:0]          m_cmd_ack,
  input  logic [MASK_W*NUM_MST-1:0]   m_wr_mask,
  input  logic [DATA_W*NUM_MST-1:0]   m_wr_data,
  output logic [NUM_MST-1:0]          m_wr_ack,
  output logic [NUM_MST-1:0]          m_rd_valid,
  output logic [DATA_W-1:0]           m_rd_data,
  cram_arb_if.master                  mem,
  output logic                        arb_err
);

  logic [1:0]         state;
  logic [MST_W-1:0]   owner;
  logic [MST_W-1:0]   rr_ptr;
  logic [BL_W-1:0]    wcnt;
  cmd_t               cmd_q;
  cmd_t               cmd_sel;
  logic [NUM_MST-1:0] pick_grant;
  logic [MST_W-1:0]   pick_idx;
  logic               pick_any;
  logic               word_hit;
  logic               burst_done;
  logic               wd_fire;

  function automatic logic [MST_W-1:0] ptr_after(input logic [MST_W-1:0] cur);
    if (int'(cur) >= NUM_MST - 1) return '0;
    return cur + MST_W'(1);
  endfunction

  cram_arb_rr #(.NUM_MST(NUM_MST)) u_rr (
    .req   (m_cmd_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (pick_grant[i]) begin
        cmd_sel.instr = m_cmd_instr[i*INSTR_W +: INSTR_W];
        cmd_sel.bl    = m_cmd_bl[i*BL_W +: BL_W];
        cmd_sel.addr  = m_cmd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Only returns tagged with the owner count; tags >= NUM_MST can never equal owner.
  assign word_hit = cmd_q.instr[INSTR_RD_BIT]
                  ? (mem.mem_rd_req && (mem.mem_rd_master == owner))
                  : (mem.mem_wr_ack && (mem.mem_wr_master == owner));
  assign burst_done = (state == ST_BUSY) && word_hit && (wcnt == cmd_q.bl);

  // Grant / command / burst-count stage
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
      cmd_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_done && pick_any) begin
            owner <= pick_idx;
            cmd_q <= cmd_sel;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.mem_cmd_ack) state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (burst_done) begin
            state  <= ST_IDLE;
            rr_ptr <= ptr_after(owner);
            wcnt   <= '0;
          end else if (word_hit) begin
            wcnt <= wcnt + BL_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (wd_fire) begin
        state  <= ST_IDLE;
        rr_ptr <= ptr_after(owner);
        wcnt   <= '0;
      end
    end
  end

`ifdef CRAM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state != ST_IDLE) && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog stage
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      wd_cnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      if (state == ST_IDLE || wd_fire) wd_cnt <= '0;
      else                             wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire) arb_err <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign arb_err = 1'b0;
`endif

  assign mem.mem_cmd_req       = (state == ST_REQ);
  assign mem.mem_cmd_instr     = cmd_q.instr;
  assign mem.mem_cmd_bl        = cmd_q.bl;
  assign mem.mem_cmd_byte_addr = cmd_q.addr;
  assign mem.mem_cmd_master    = owner;
  assign m_rd_data             = mem.mem_rd_data;

  always_comb begin
    m_cmd_ack       = '0;
    m_wr_ack        = '0;
    m_rd_valid      = '0;
    mem.mem_wr_data = '0;
    mem.mem_wr_mask = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      m_cmd_ack[i]  = (state == ST_REQ) && mem.mem_cmd_ack && (owner == MST_W'(i));
      m_wr_ack[i]   = mem.mem_wr_ack && (mem.mem_wr_master == MST_W'(i));
      m_rd_valid[i] = mem.mem_rd_req && (mem.mem_rd_master == MST_W'(i));
      if (owner == MST_W'(i)) begin
        mem.mem_wr_data = m_wr_data[i*DATA_W +: DATA_W];
        mem.mem_wr_mask = m_wr_mask[i*MASK_W +: MASK_W];
      end
    end
  end

endmodule

// File: tb/tb_cram_arb.sv
// Directed bench for cram_arb; the watchdog scenario runs when CRAM_ARB_TIMEOUT_EN is defined.
module tb_cram_arb;
  import cram_arb_pkg::*;

  localparam int N = 4;

  logic           mem_clk = 1'b0;
  logic           mem_rst_n;
  logic           init_done;
  logic [N-1:0]   m_cmd_req;
  logic [3*N-1:0] m_cmd_instr;
  logic [6*N-1:0] m_cmd_bl;
  logic [30*N-1:0] m_cmd_addr;
  logic [N-1:0]   m_cmd_ack;
  logic [4*N-1:0] m_wr_mask;
  logic [32*N-1:0] m_wr_data;
  logic [N-1:0]   m_wr_ack;
  logic [N-1:0]   m_rd_valid;
  logic [31:0]    m_rd_data;
  logic           arb_err;

  int checks = 0;
  int errors = 0;

  cram_arb_if mem_if();

  cram_arb #(.NUM_MST(N), .TIMEOUT(16)) dut (
    .mem_clk     (mem_clk),
    .mem_rst_n   (mem_rst_n),
    .init_done   (init_done),
    .m_cmd_req   (m_cmd_req),
    .m_cmd_instr (m_cmd_instr),
    .m_cmd_bl    (m_cmd_bl),
    .m_cmd_addr  (m_cmd_addr),
    .m_cmd_ack   (m_cmd_ack),
    .m_wr_mask   (m_wr_mask),
    .m_wr_data   (m_wr_data),
    .m_wr_ack    (m_wr_ack),
    .m_rd_valid  (m_rd_valid),
    .m_rd_data   (m_rd_data),
    .mem         (mem_if),
    .arb_err     (arb_err)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [2:0] instr, input logic [5:0] bl,
                         input logic [29:0] addr);
    m_cmd_instr[i*3 +: 3]  = instr;
    m_cmd_bl[i*6 +: 6]     = bl;
    m_cmd_addr[i*30 +: 30] = addr;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (mem_if.mem_cmd_req !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (mem_if.mem_cmd_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_req timeout mem_cmd_req=%b want 1", mem_if.mem_cmd_req);
    end
  endtask

  task automatic apply_reset();
    mem_rst_n = 1'b0;
    init_done = 1'b0;
    m_cmd_req = '0;
    m_cmd_instr = '0;
    m_cmd_bl = '0;
    m_cmd_addr = '0;
    m_wr_mask = '0;
    m_wr_data = '0;
    mem_if.mem_cmd_ack = 1'b0;
    mem_if.mem_wr_ack = 1'b0;
    mem_if.mem_wr_master = '0;
    mem_if.mem_rd_req = 1'b0;
    mem_if.mem_rd_data = '0;
    mem_if.mem_rd_master = '0;
    tick();
    tick();
    mem_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b0 || mem_if.mem_cmd_master !== 3'd0 || mem_if.mem_cmd_bl !== 6'd0) begin
      errors++;
      $display("FAIL reset_cmd req=%b master=%0d bl=%0d want 0 0 0",
               mem_if.mem_cmd_req, mem_if.mem_cmd_master, mem_if.mem_cmd_bl);
    end
    checks++;
    if (m_cmd_ack !== 4'b0 || m_wr_ack !== 4'b0 || m_rd_valid !== 4'b0 || arb_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs cmd_ack=%b wr_ack=%b rd_valid=%b err=%b want 0",
               m_cmd_ack, m_wr_ack, m_rd_valid, arb_err);
    end
  endtask

  task automatic test_init_gate_and_read();
    set_cmd(1, 3'b001, 6'd0, 30'h40);
    m_cmd_req = 4'b0010;
    repeat (4) tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL init_gate mem_cmd_req=%b want 0", mem_if.mem_cmd_req);
    end
    init_done = 1'b1;
    tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b1 || mem_if.mem_cmd_master !== 3'd1 ||
        mem_if.mem_cmd_instr !== 3'b001 || mem_if.mem_cmd_byte_addr !== 30'h40) begin
      errors++;
      $display("FAIL init_grant req=%b master=%0d instr=%0d addr=%0h want 1 1 1 40",
               mem_if.mem_cmd_req, mem_if.mem_cmd_master, mem_if.mem_cmd_instr,
               mem_if.mem_cmd_byte_addr);
    end
    set_cmd(0, 3'b001, 6'd1, 30'h80);
    m_cmd_req[0] = 1'b1;
    mem_if.mem_cmd_ack = 1'b1;
    #1;
    checks++;
    if (m_cmd_ack !== 4'b0010) begin
      errors++;
      $display("FAIL cmd_ack_m1 got %b want 0010", m_cmd_ack);
    end
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    m_cmd_req[1] = 1'b0;
    checks++;
    if (mem_if.mem_cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop mem_cmd_req=%b want 0", mem_if.mem_cmd_req);
    end
    mem_if.mem_rd_req = 1'b1;
    mem_if.mem_rd_master = 3'd1;
    mem_if.mem_rd_data = 32'hCAFE_0001;
    #1;
    checks++;
    if (m_rd_valid !== 4'b0010 || m_rd_data !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL rd_steer valid=%b data=%h want 0010 cafe0001", m_rd_valid, m_rd_data);
    end
    tick();
    mem_if.mem_rd_req = 1'b0;
    tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b1 || mem_if.mem_cmd_master !== 3'd0 || mem_if.mem_cmd_bl !== 6'd1) begin
      errors++;
      $display("FAIL next_m0 req=%b master=%0d bl=%0d want 1 0 1",
               mem_if.mem_cmd_req, mem_if.mem_cmd_master, mem_if.mem_cmd_bl);
    end
  endtask

  task automatic test_stray_tags();
    set_cmd(3, 3'b000, 6'd0, 30'h300);
    m_wr_data[3*32 +: 32] = 32'h3333_ABCD;
    m_wr_mask[3*4 +: 4] = 4'b0101;
    m_cmd_req[3] = 1'b1;
    mem_if.mem_cmd_ack = 1'b1;
    #1;
    checks++;
    if (m_cmd_ack !== 4'b0001) begin
      errors++;
      $display("FAIL cmd_ack_m0 got %b want 0001", m_cmd_ack);
    end
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    m_cmd_req[0] = 1'b0;
    mem_if.mem_rd_req = 1'b1;
    mem_if.mem_rd_master = 3'd5;
    #1;
    checks++;
    if (m_rd_valid !== 4'b0000) begin
      errors++;
      $display("FAIL stray_rd valid=%b want 0000", m_rd_valid);
    end
    tick();
    mem_if.mem_rd_req = 1'b0;
    mem_if.mem_wr_ack = 1'b1;
    mem_if.mem_wr_master = 3'd6;
    #1;
    checks++;
    if (m_wr_ack !== 4'b0000) begin
      errors++;
      $display("FAIL stray_wr ack=%b want 0000", m_wr_ack);
    end
    tick();
    mem_if.mem_wr_ack = 1'b0;
    mem_if.mem_rd_req = 1'b1;
    mem_if.mem_rd_master = 3'd0;
    #1;
    checks++;
    if (m_rd_valid !== 4'b0001) begin
      errors++;
      $display("FAIL rd_m0 valid=%b want 0001", m_rd_valid);
    end
    tick();
    mem_if.mem_rd_req = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_counted mem_cmd_req=%b want 0", mem_if.mem_cmd_req);
    end
    mem_if.mem_rd_req = 1'b1;
    tick();
    mem_if.mem_rd_req = 1'b0;
    tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b1 || mem_if.mem_cmd_master !== 3'd3) begin
      errors++;
      $display("FAIL grant_m3 req=%b master=%0d want 1 3", mem_if.mem_cmd_req, mem_if.mem_cmd_master);
    end
    mem_if.mem_cmd_ack = 1'b1;
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    m_cmd_req[3] = 1'b0;
    mem_if.mem_wr_ack = 1'b1;
    mem_if.mem_wr_master = 3'd3;
    #1;
    checks++;
    if (m_wr_ack !== 4'b1000 || mem_if.mem_wr_data !== 32'h3333_ABCD || mem_if.mem_wr_mask !== 4'b0101) begin
      errors++;
      $display("FAIL wr_m3 ack=%b data=%h mask=%b want 1000 3333abcd 0101",
               m_wr_ack, mem_if.mem_wr_data, mem_if.mem_wr_mask);
    end
    tick();
    mem_if.mem_wr_ack = 1'b0;
  endtask

  task automatic test_single_write();
    set_cmd(2, 3'b000, 6'd3, 30'h100);
    m_wr_mask[2*4 +: 4] = 4'b0000;
    m_wr_data[2*32 +: 32] = 32'h2000_0000;
    m_cmd_req = 4'b0100;
    tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b1 || mem_if.mem_cmd_master !== 3'd2 || mem_if.mem_cmd_bl !== 6'd3 ||
        mem_if.mem_cmd_byte_addr !== 30'h100 || mem_if.mem_cmd_instr !== 3'b000) begin
      errors++;
      $display("FAIL wr_grant req=%b master=%0d bl=%0d addr=%h instr=%0d want 1 2 3 100 0",
               mem_if.mem_cmd_req, mem_if.mem_cmd_master, mem_if.mem_cmd_bl,
               mem_if.mem_cmd_byte_addr, mem_if.mem_cmd_instr);
    end
    mem_if.mem_cmd_ack = 1'b1;
    #1;
    checks++;
    if (m_cmd_ack !== 4'b0100) begin
      errors++;
      $display("FAIL cmd_ack_m2 got %b want 0100", m_cmd_ack);
    end
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    m_cmd_req = 4'b0001;
    set_cmd(0, 3'b000, 6'd0, 30'h0);
    m_wr_data[0 +: 32] = 32'h0BAD_0BAD;
    for (int w = 0; w < 4; w++) begin
      m_wr_data[2*32 +: 32] = 32'h2000_0000 + 32'(w);
      mem_if.mem_wr_ack = 1'b1;
      mem_if.mem_wr_master = 3'd2;
      #1;
      checks++;
      if (m_wr_ack !== 4'b0100 || mem_if.mem_wr_data !== 32'h2000_0000 + 32'(w)) begin
        errors++;
        $display("FAIL wr_word%0d ack=%b data=%h want 0100 %h",
                 w, m_wr_ack, mem_if.mem_wr_data, 32'h2000_0000 + 32'(w));
      end
      tick();
      mem_if.mem_wr_ack = 1'b0;
      checks++;
      if (mem_if.mem_cmd_req !== 1'b0) begin
        errors++;
        $display("FAIL wr_busy%0d mem_cmd_req=%b want 0", w, mem_if.mem_cmd_req);
      end
      if (w < 3) tick();
    end
    tick();
    checks++;
    if (mem_if.mem_cmd_req !== 1'b1 || mem_if.mem_cmd_master !== 3'd0) begin
      errors++;
      $display("FAIL after_burst req=%b master=%0d want 1 0", mem_if.mem_cmd_req, mem_if.mem_cmd_master);
    end
    mem_if.mem_cmd_ack = 1'b1;
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    m_cmd_req = 4'b0000;
    mem_if.mem_wr_ack = 1'b1;
    mem_if.mem_wr_master = 3'd0;
    tick();
    mem_if.mem_wr_ack = 1'b0;
  endtask

  task automatic test_rr_order();
    int exp_order[4];
    exp_order = '{0, 1, 3, 0};
    apply_reset();
    init_done = 1'b1;
    set_cmd(0, 3'b000, 6'd0, 30'h10);
    set_cmd(1, 3'b000, 6'd0, 30'h20);
    set_cmd(3, 3'b000, 6'd0, 30'h30);
    m_cmd_req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_req(8);
      checks++;
      if (mem_if.mem_cmd_master !== 3'(exp_order[k])) begin
        errors++;
        $display("FAIL rr_grant%0d master=%0d want %0d", k, mem_if.mem_cmd_master, exp_order[k]);
      end
      mem_if.mem_cmd_ack = 1'b1;
      #1;
      checks++;
      if (m_cmd_ack !== 4'(1 << exp_order[k])) begin
        errors++;
        $display("FAIL rr_ack%0d got %b want %b", k, m_cmd_ack, 4'(1 << exp_order[k]));
      end
      tick();
      mem_if.mem_cmd_ack = 1'b0;
      mem_if.mem_wr_ack = 1'b1;
      mem_if.mem_wr_master = 3'(exp_order[k]);
      if (k == 3) m_cmd_req = 4'b0000;
      tick();
      mem_if.mem_wr_ack = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    set_cmd(1, 3'b001, 6'd5, 30'h55);
    m_cmd_req = 4'b0010;
    wait_req(8);
    checks++;
    if (mem_if.mem_cmd_master !== 3'd1) begin
      errors++;
      $display("FAIL pre_rst master=%0d want 1", mem_if.mem_cmd_master);
    end
    #3;
    mem_rst_n = 1'b0;
    #1;
    checks++;
    if (mem_if.mem_cmd_req !== 1'b0 || mem_if.mem_cmd_master !== 3'd0 || mem_if.mem_cmd_bl !== 6'd0) begin
      errors++;
      $display("FAIL async_rst req=%b master=%0d bl=%0d want 0 0 0",
               mem_if.mem_cmd_req, mem_if.mem_cmd_master, mem_if.mem_cmd_bl);
    end
    tick();
    mem_rst_n = 1'b1;
    set_cmd(0, 3'b000, 6'd0, 30'h4);
    m_cmd_req = 4'b0011;
    wait_req(8);
    checks++;
    if (mem_if.mem_cmd_master !== 3'd0) begin
      errors++;
      $display("FAIL rr_ptr_rst master=%0d want 0", mem_if.mem_cmd_master);
    end
    mem_if.mem_cmd_ack = 1'b1;
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    m_cmd_req = 4'b0000;
    mem_if.mem_wr_ack = 1'b1;
    mem_if.mem_wr_master = 3'd0;
    tick();
    mem_if.mem_wr_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
`ifdef CRAM_ARB_TIMEOUT_EN
    int n;
    apply_reset();
    init_done = 1'b1;
    set_cmd(0, 3'b000, 6'd0, 30'h0);
    set_cmd(2, 3'b000, 6'd0, 30'h8);
    m_cmd_req = 4'b0101;
    wait_req(8);
    n = 0;
    while (mem_if.mem_cmd_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16 || arb_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout req_cycles=%0d err=%b want 16 1", n, arb_err);
    end
    wait_req(8);
    checks++;
    if (mem_if.mem_cmd_master !== 3'd2) begin
      errors++;
      $display("FAIL timeout_next master=%0d want 2", mem_if.mem_cmd_master);
    end
    m_cmd_req = 4'b0000;
    mem_if.mem_cmd_ack = 1'b1;
    tick();
    mem_if.mem_cmd_ack = 1'b0;
    mem_if.mem_wr_ack = 1'b1;
    mem_if.mem_wr_master = 3'd2;
    tick();
    mem_if.mem_wr_ack = 1'b0;
    tick();
    checks++;
    if (arb_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky err=%b want 1", arb_err);
    end
`else
    checks++;
    if (arb_err !== 1'b0) begin
      errors++;
      $display("FAIL err_tied err=%b want 0", arb_err);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_init_gate_and_read();
    test_stray_tags();
    test_single_write();
    test_rr_order();
    test_async_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
